// File: rtl/scan_chain_driver_pkg.sv
// Shared types and helpers for the scan-chain driver.
package scan_chain_driver_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT     = 2'b00,
    OP_SHIFT_UPD = 2'b01,
    OP_SRESET    = 2'b10,
    OP_RSVD      = 2'b11
  } cmd_op_e;

  typedef enum logic [3:0] {
    StIdle,
    StSetup,
    StClkP,
    StGap1,
    StClkN,
    StGap2,
    StUpdate,
    StSrst,
    StDone
  } state_e;

  function automatic int unsigned phase_width(int unsigned div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/scan_chain_driver_if.sv
// Host command/response and scan-chain pin bundle for scan_chain_driver.
interface scan_chain_driver_if import scan_chain_driver_pkg::*; #(
  parameter int unsigned CHAIN_LENGTH = 87
);
  logic                    CmdValid;
  logic                    CmdReady;
  cmd_op_e                 CmdOp;
  logic [CHAIN_LENGTH-1:0] TxData;
  logic                    RspValid;
  logic [CHAIN_LENGTH-1:0] RxData;
  logic                    SClkP;
  logic                    SClkN;
  logic                    SReset;
  logic                    SEnable;
  logic                    SUpdate;
  logic                    SIn;
  logic                    SOut;

  // Host plus chain side: issues commands and returns SOut.
  modport master (
    output CmdValid, CmdOp, TxData, SOut,
    input  CmdReady, RspValid, RxData, SClkP, SClkN, SReset, SEnable, SUpdate, SIn
  );

  modport slave (
    input  CmdValid, CmdOp, TxData, SOut,
    output CmdReady, RspValid, RxData, SClkP, SClkN, SReset, SEnable, SUpdate, SIn
  );
endinterface

// File: rtl/scan_phase_timer.sv
// Loadable down-counter timing one DIV-cycle scan phase.
module scan_phase_timer import scan_chain_driver_pkg::*; #(
  parameter int unsigned DIV = 2
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic Load,
  output logic PhaseLast
);
  localparam int unsigned PW = phase_width(DIV);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= PW'(DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign PhaseLast = (cnt_q == '0);
endmodule

// File: rtl/scan_chain_driver.sv
// Drives a two-phase scan chain from host commands; SOut readback is built only
// when SCAN_CHAIN_DRIVER_READBACK_EN is defined, otherwise RxData is constant 0.
module scan_chain_driver import scan_chain_driver_pkg::*; #(
  parameter int unsigned CHAIN_LENGTH = 87,
  parameter int unsigned DIV          = 2
) (
  input logic               Clk,
  input logic               ResetN,
  scan_chain_driver_if.slave bus
);
  localparam int unsigned BW = (CHAIN_LENGTH > 1) ? $clog2(CHAIN_LENGTH) : 1;
  localparam logic [BW-1:0] LastBit = BW'(CHAIN_LENGTH - 1);

  state_e                  state_q, state_d;
  cmd_op_e                 op_q;
  logic [CHAIN_LENGTH-1:0] tx_q;
  logic [BW-1:0]           bit_q;
  logic ready_q, rsp_q, sclkp_q, sclkn_q, sreset_q, senable_q, supdate_q, sin_q;
  logic phase_last, accept, timed, advance, shift_d;

  assign accept  = bus.CmdValid && ready_q;
  assign timed   = !(state_q inside {StIdle, StDone});
  assign advance = accept || (timed && phase_last);
  assign shift_d = state_d inside {StSetup, StClkP, StGap1, StClkN, StGap2};

  scan_phase_timer #(.DIV(DIV)) u_timer (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .Load     (advance),
    .PhaseLast(phase_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.CmdOp)
            OP_SHIFT, OP_SHIFT_UPD: state_d = StSetup;
            OP_SRESET:              state_d = StSrst;
            default:                state_d = StDone;
          endcase
        end
      end
      StSetup: if (phase_last) state_d = StClkP;
      StClkP:  if (phase_last) state_d = StGap1;
      StGap1:  if (phase_last) state_d = StClkN;
      StClkN:  if (phase_last) state_d = StGap2;
      StGap2: begin
        if (phase_last) begin
          if (bit_q != LastBit)          state_d = StSetup;
          else if (op_q == OP_SHIFT_UPD) state_d = StUpdate;
          else                           state_d = StDone;
        end
      end
      StUpdate, StSrst: if (phase_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
  logic [CHAIN_LENGTH-1:0] rx_q, rxdata_q;
  assign bus.RxData = rxdata_q;
`else
  assign bus.RxData = '0;
`endif

  // Outputs are registered from the next state so pins change cleanly with the state.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q   <= StIdle;
      op_q      <= OP_SHIFT;
      tx_q      <= '0;
      bit_q     <= '0;
      ready_q   <= 1'b0;
      rsp_q     <= 1'b0;
      sclkp_q   <= 1'b0;
      sclkn_q   <= 1'b0;
      sreset_q  <= 1'b0;
      senable_q <= 1'b0;
      supdate_q <= 1'b0;
      sin_q     <= 1'b0;
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
      rx_q      <= '0;
      rxdata_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == StIdle);
      rsp_q     <= (state_d == StDone);
      sclkp_q   <= (state_d == StClkP);
      sclkn_q   <= (state_d == StClkN);
      sreset_q  <= (state_d == StSrst);
      supdate_q <= (state_d == StUpdate);
      senable_q <= shift_d;
      if (accept) begin
        op_q  <= bus.CmdOp;
        tx_q  <= bus.TxData;
        bit_q <= '0;
      end
      // First bit comes straight from TxData since tx_q loads on the same edge.
      if (state_d == StSetup && state_q != StSetup) begin
        sin_q <= accept ? bus.TxData[CHAIN_LENGTH-1] : tx_q[CHAIN_LENGTH-1];
      end else if (!shift_d) begin
        sin_q <= 1'b0;
      end
      if (state_q == StSetup && phase_last) begin
        tx_q <= tx_q << 1;
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
        rx_q <= {rx_q[CHAIN_LENGTH-2:0], bus.SOut};
`endif
      end
      if (state_q == StGap2 && phase_last) begin
        bit_q <= bit_q + 1'b1;
      end
`ifdef SCAN_CHAIN_DRIVER_READBACK_EN
      if (state_d == StDone && state_q != StIdle && op_q inside {OP_SHIFT, OP_SHIFT_UPD}) begin
        rxdata_q <= rx_q;
      end
`endif
    end
  end

  assign bus.CmdReady = ready_q;
  assign bus.RspValid = rsp_q;
  assign bus.SClkP    = sclkp_q;
  assign bus.SClkN    = sclkn_q;
  assign bus.SReset   = sreset_q;
  assign bus.SEnable  = senable_q;
  assign bus.SUpdate  = supdate_q;
  assign bus.SIn      = sin_q;
endmodule

// File: doc/scan_chain_driver.md
# scan_chain_driver

Host-side driver that sits directly upstream of a generated scan chain, such as `test_scan_chain`. It accepts one command at a time from an on-chip host, such as an SPI/JTAG bridge:

- shift a full chain word in,
- optionally pulse update, or
- pulse scan reset.

It synthesizes the two-phase non-overlapping SClkP/SClkN, SEnable, SUpdate, SReset and SIn from one system clock, and captures SOut into a parallel readback word.

## Interface
Parameters:
- CHAIN_LENGTH, 87, total scan-chain bits (matches the chain's TotalLength).
- DIV, 2, system-clock cycles per scan phase; legal range 1..255.

Ports:
- Clk  input  1  system clock; the only clock.
- ResetN  input  1  reset, synchronous and active-low.
- CmdValid  input  1  command request.
- CmdReady  output  1  high only in IDLE.
- CmdOp  input  2  00 shift-only, 01 shift+update, 10 scan reset, 11 reserved.
- TxData  input  CHAIN_LENGTH  word to shift in; sampled at the accept edge.
- RspValid  output  1  one-cycle completion pulse.
- RxData  output  CHAIN_LENGTH  chain contents shifted out; held until the next shift completes.
- SClkP, SClkN  output  1  non-overlapping scan clocks.
- SReset, SEnable, SUpdate, SIn  output  1  scan control and data.
- SOut  input  1  chain serial output.

## Operation
- A command is accepted on the edge where CmdValid && CmdReady. TxData and CmdOp are latched into internal registers at that edge.
- States: IDLE, SETUP, CLKP, GAP1, CLKN, GAP2, UPDATE, SRST, DONE.
- Every non-IDLE/DONE state lasts exactly DIV cycles, timed by a phase counter.
- Shift sequence, per bit, repeated CHAIN_LENGTH times:
  - SETUP: SIn = shift register MSB.
  - CLKP: SClkP=1.
  - GAP1: both clocks low.
  - CLKN: SClkN=1.
  - GAP2: both clocks low.
  - SEnable=1 from the first SETUP cycle through the last GAP2 cycle.
  - SIn holds its value from SETUP through GAP2.
- SOut is sampled in the last cycle of each SETUP phase, shifted into the receive register LSB, then the shift register shifts left by one.
  - After CHAIN_LENGTH bits, RxData[CHAIN_LENGTH-1] is the first SOut bit sampled.
  - TxData[CHAIN_LENGTH-1] is the first bit driven.
- Bit counter range: 0..CHAIN_LENGTH-1; after the bit at count CHAIN_LENGTH-1 finishes GAP2:
  - op 00 → DONE.
  - op 01 → UPDATE, with SEnable=0 and SUpdate=1 for DIV cycles, then DONE.
- op 10 → SRST: SReset=1 and SEnable=0 for DIV cycles, then DONE; RxData unchanged.
- op 11 → DONE directly; no scan activity; RxData unchanged.
- DONE: RspValid=1 for one cycle; RxData is updated in the same cycle (shift ops only); next state IDLE.
- SClkP and SClkN are never high in the same cycle. At least DIV low cycles separate any SClkP high from any SClkN high.
- CmdValid outside IDLE is ignored (CmdReady=0); there is no queueing.
- ResetN low at any time: on that edge, all outputs and state return to reset values, the command in flight is abandoned, and no RspValid is issued.

## Timing
- Reset values:
  - CmdReady=0 while ResetN is low, 1 in the first cycle after release.
  - SClkP, SClkN, SReset, SEnable, SUpdate, SIn, RspValid = 0.
  - RxData = 0.
- All scan outputs are registered, so there are no glitches.
- Accept at edge 0 → first SETUP cycle is cycle 1.
- Shift-only: RspValid in cycle 5·DIV·CHAIN_LENGTH + 1.
- Shift+update: RspValid in cycle 5·DIV·CHAIN_LENGTH + DIV + 1.
- Scan reset: RspValid in cycle DIV + 1.
- Reserved op: RspValid in cycle 1.
- CmdReady returns high the cycle after RspValid, so back-to-back commands are accepted every (latency+1) cycles.

## Configuration
- SCAN_CHAIN_DRIVER_READBACK_EN:
  - Defined: SOut is sampled and RxData is produced as above.
  - Undefined: the receive register is removed, SOut is ignored, RxData is constant 0, and timing is unchanged.

## Structure
- scan_chain_driver_pkg holds:
  - the cmd_op_e enum (OP_SHIFT, OP_SHIFT_UPD, OP_SRESET, OP_RSVD),
  - the state_e enum,
  - the phase-count width function $clog2(DIV+1).
- One sub-module: scan_phase_timer. It is a loadable down-counter that loads DIV-1 on each phase entry and asserts PhaseLast when it reaches 0.

## Test plan
All scenarios use CHAIN_LENGTH=87, DIV=2 unless stated.

- Reset: hold ResetN low 3 cycles → all outputs 0; CmdReady=1 one cycle after release.
- Shift-only, TxData=87'h5A5…, SOut looped from a behavioural 87-bit chain preloaded with all-ones → RspValid at cycle 871; RxData = all-ones; chain holds TxData; SUpdate never high.
- Shift+update, TxData=1 → SUpdate high exactly cycles 871–872; RspValid at 873; SClkP and SClkN never both high (assertion).
- Scan reset → SReset high cycles 1–2; RspValid at 3; RxData unchanged.
- CmdValid held high during a shift → no second accept until after RspValid. ResetN pulsed low mid-shift at cycle 400 → no RspValid, all scan outputs 0 next cycle.
- DIV=1, READBACK_EN undefined → shift-only RspValid at cycle 436; RxData stays 0.
